// File: rtl/token_buffer_arb.sv
// token_buffer_arb
// Single-port token row buffer shared by NUM_CH requesters. One access per
// cycle is granted (fixed external select or round-robin) and registered into
// stage s1. From s1 the access is either written into the SRAM or read out,
// with the read data appearing one cycle later under a one-hot tagged valid.
// Accesses that violate the per-channel permission masks never touch the SRAM
// and raise a one-cycle out_err pulse for the granted channel instead.
module token_buffer_arb #(
    parameter int                DATA_W   = 1024,
    parameter int                ADDR_W   = 8,
    parameter int                NUM_CH   = 4,
    parameter int                ARB_MODE = 0,
    parameter logic [NUM_CH-1:0] WR_MASK  = 4'b1101,
    parameter logic [NUM_CH-1:0] RD_MASK  = 4'b1011,
    localparam int               CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CW-1:0]            in_src_sel,
    input  logic [NUM_CH-1:0]        in_req,
    input  logic [NUM_CH-1:0]        in_we,
    input  logic [NUM_CH*ADDR_W-1:0] in_addr,
    input  logic [NUM_CH*DATA_W-1:0] in_wdata,
    output logic [NUM_CH-1:0]        out_gnt,
    output logic [DATA_W-1:0]        out_rdata,
    output logic [NUM_CH-1:0]        out_rdata_valid,
    output logic [NUM_CH-1:0]        out_err,
    output logic [31:0]              out_busy_cnt
);

    localparam int          DEPTH   = 2 ** ADDR_W;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Permission lookup: writes are checked against WR_MASK, reads against RD_MASK.
    function automatic logic access_ok(input logic we, input logic [CW-1:0] ch);
        logic ok;
        if (we) begin
            ok = WR_MASK[ch];
        end else begin
            ok = RD_MASK[ch];
        end
        return ok;
    endfunction

    // Round-robin successor of a channel index, wrapping NUM_CH-1 -> 0.
    function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] ch);
        logic [CW-1:0] n;
        if (int'(ch) == NUM_CH - 1) begin
            n = {CW{1'b0}};
        end else begin
            n = ch + 1'b1;
        end
        return n;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [CW-1:0]     rr_ptr_r;
    logic [NUM_CH-1:0] gnt_s;
    logic [CW-1:0]     gnt_ch_s;
    logic              gnt_any_s;
    logic [CW-1:0]     cand_s;
    logic              ok_s;

    logic              s1_vld_r;
    logic [NUM_CH-1:0] s1_gnt_r;
    logic              s1_we_r;
    logic [ADDR_W-1:0] s1_addr_r;
    logic [DATA_W-1:0] s1_wdata_r;
    logic              s1_ok_r;

    logic [DATA_W-1:0] rdata_r;
    logic [NUM_CH-1:0] rdata_valid_r;
    logic [NUM_CH-1:0] err_r;
    logic [31:0]       busy_cnt_r;

    // Arbitration: pick at most one channel this cycle; nothing is granted during reset.
    always_comb begin
        gnt_s     = {NUM_CH{1'b0}};
        gnt_ch_s  = {CW{1'b0}};
        gnt_any_s = 1'b0;
        cand_s    = {CW{1'b0}};
        if (rst) begin
            gnt_any_s = 1'b0;
        end else if (ARB_MODE == 0) begin
            if ((int'(in_src_sel) < NUM_CH) && in_req[in_src_sel]) begin
                gnt_ch_s  = in_src_sel;
                gnt_any_s = 1'b1;
            end else begin
                gnt_any_s = 1'b0;
            end
        end else begin
            // Walk from the farthest offset inward so the nearest requester at or after rr_ptr wins.
            for (int off = NUM_CH - 1; off >= 0; off--) begin
                cand_s = CW'((int'(rr_ptr_r) + off) % NUM_CH);
                if (in_req[cand_s]) begin
                    gnt_ch_s  = cand_s;
                    gnt_any_s = 1'b1;
                end else begin
                    gnt_ch_s  = gnt_ch_s;
                end
            end
        end
        if (gnt_any_s) begin
            gnt_s[gnt_ch_s] = 1'b1;
        end else begin
            gnt_s = {NUM_CH{1'b0}};
        end
        ok_s = access_ok(in_we[gnt_ch_s], gnt_ch_s);
    end

    // SRAM write port: only permitted writes held in s1 update the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && s1_vld_r && s1_we_r && s1_ok_r) begin
            mem_r[s1_addr_r] <= s1_wdata_r;
        end
    end

    // Access pipeline: capture the grant into s1, then produce read data, error pulse and busy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r      <= {CW{1'b0}};
            s1_vld_r      <= 1'b0;
            s1_gnt_r      <= {NUM_CH{1'b0}};
            s1_we_r       <= 1'b0;
            s1_addr_r     <= {ADDR_W{1'b0}};
            s1_wdata_r    <= {DATA_W{1'b0}};
            s1_ok_r       <= 1'b0;
            rdata_r       <= {DATA_W{1'b0}};
            rdata_valid_r <= {NUM_CH{1'b0}};
            err_r         <= {NUM_CH{1'b0}};
            busy_cnt_r    <= 32'd0;
        end else begin
            s1_vld_r   <= gnt_any_s;
            s1_gnt_r   <= gnt_s;
            s1_we_r    <= in_we[gnt_ch_s];
            s1_addr_r  <= in_addr[int'(gnt_ch_s) * ADDR_W +: ADDR_W];
            s1_wdata_r <= in_wdata[int'(gnt_ch_s) * DATA_W +: DATA_W];
            s1_ok_r    <= ok_s;
            err_r      <= (gnt_any_s && !ok_s) ? gnt_s : {NUM_CH{1'b0}};
            if (gnt_any_s) begin
                rr_ptr_r <= next_ch(gnt_ch_s);
            end
            if (s1_vld_r && !s1_we_r && s1_ok_r) begin
                rdata_r       <= mem_r[s1_addr_r];
                rdata_valid_r <= s1_gnt_r;
            end else begin
                rdata_r       <= {DATA_W{1'b0}};
                rdata_valid_r <= {NUM_CH{1'b0}};
            end
            if (s1_vld_r && (busy_cnt_r != CNT_MAX)) begin
                busy_cnt_r <= busy_cnt_r + 32'd1;
            end
        end
    end

    assign out_gnt         = gnt_s;
    assign out_rdata       = rdata_r;
    assign out_rdata_valid = rdata_valid_r;
    assign out_err         = err_r;
    assign out_busy_cnt    = busy_cnt_r;

endmodule
